pe_row_seq_ctrl: RTL and testbench

//  Sequencer for one 16-PE row (16 PEs + 2-stage adder tree, 8-bit signed row sum).
//  - Per layer: loops over cfg_pass_num channel passes. Each pass requests a weight

---
 rtl/ecg_acc_pkg.sv | 10 +
 rtl/pe_row_seq_ctrl_if.sv | 28 ++
 rtl/pe_row_out_fifo.sv | 45 ++++
 rtl/pe_row_seq_ctrl.sv | 106 ++++++++++
 tb/tb_pe_row_seq_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ecg_acc_pkg.sv
// ecg_acc_pkg: shared FSM states and row/accumulator constants
package ecg_acc_pkg;
  localparam int PIPE_LAT    = 3;
  localparam int ACC_W       = 16;
  localparam int MAX_LEN     = 64;
  localparam int LEN_W       = 7;
  localparam int PASS_W      = 5;
  localparam int OFIFO_DEPTH = 4;
  typedef enum logic [2:0] {IDLE, WLOAD, WPULSE, STREAM, DRAIN, FIN} state_t;
endpackage

// File: rtl/pe_row_seq_ctrl_if.sv
// pe_row_seq_ctrl_if: config, weight-load, slide-stream and result handshakes of one PE row
interface pe_row_seq_ctrl_if;
  import ecg_acc_pkg::*;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [LEN_W-1:0]  cfg_out_len;
  logic [PASS_W-1:0] cfg_pass_num;
  logic              wload_req;
  logic              wload_ack;
  logic              new_weight_val;
  logic              din_valid;
  logic              din_ready;
  logic              slide_en;
  logic [7:0]        row_result;
  logic [ACC_W-1:0]  acc_data;
  logic              acc_valid;
  logic              acc_ready;
  logic              busy;
  logic              done;
  modport master (
    input  cfg_valid, cfg_out_len, cfg_pass_num, wload_ack, din_valid, row_result, acc_ready,
    output cfg_ready, wload_req, new_weight_val, din_ready, slide_en, acc_data, acc_valid, busy, done
  );
  modport slave (
    output cfg_valid, cfg_out_len, cfg_pass_num, wload_ack, din_valid, row_result, acc_ready,
    input  cfg_ready, wload_req, new_weight_val, din_ready, slide_en, acc_data, acc_valid, busy, done
  );
endinterface

// File: rtl/pe_row_out_fifo.sv
// pe_row_out_fifo: synchronous result FIFO exposing its free-entry count for issue credits
module pe_row_out_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] free
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [FW-1:0] cnt;
  logic          do_push, do_pop;
  // guarded push/pop and status flags
  always_comb begin
    do_pop  = pop & (cnt != '0);
    do_push = push & ((cnt != FW'(DEPTH)) | do_pop);
    dout    = mem[rd];
    empty   = cnt == '0;
    free    = FW'(DEPTH) - cnt;
  end
  // pointer and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
      if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
      cnt <= cnt + FW'(do_push) - FW'(do_pop);
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/pe_row_seq_ctrl.sv
// pe_row_seq_ctrl: pass/window sequencer and psum accumulator for one 16-PE row
module pe_row_seq_ctrl #(
  parameter int PIPE_LAT    = ecg_acc_pkg::PIPE_LAT,
  parameter int MAX_LEN     = ecg_acc_pkg::MAX_LEN,
  parameter int OFIFO_DEPTH = ecg_acc_pkg::OFIFO_DEPTH
) (
  input logic               clk,
  input logic               rst,
  pe_row_seq_ctrl_if.master bus
);
  import ecg_acc_pkg::*;
  localparam int IW = $clog2(MAX_LEN);
  localparam int FW = $clog2(OFIFO_DEPTH + 1);
  localparam int CW = $clog2(PIPE_LAT + OFIFO_DEPTH + 1);
  state_t                  state, nxt;
  logic [LEN_W-1:0]        len_q, issue_idx, cfg_len;
  logic [PASS_W-1:0]       pass_q, pass_idx;
  logic [PIPE_LAT-1:0]     tv;
  logic [IW-1:0]           ti [PIPE_LAT];
  logic signed [ACC_W-1:0] psum [MAX_LEN];
  logic signed [ACC_W-1:0] r, acc_sum;
  logic [ACC_W-1:0]        fifo_dout;
  logic [FW-1:0]           free;
  logic [CW-1:0]           tag_cnt;
  logic [IW-1:0]           tail_i;
  logic                    f_empty, first, last, tail_v, credit_ok;
  // datapath decode: clamp, pipe tail, accumulate value and last-pass credit check
  always_comb begin
    cfg_len   = bus.cfg_out_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.cfg_out_len;
    tail_v    = tv[PIPE_LAT-1];
    tail_i    = ti[PIPE_LAT-1];
    first     = pass_idx == '0;
    last      = pass_idx == pass_q - 1'b1;
    r         = {{(ACC_W - 8){bus.row_result[7]}}, bus.row_result};
    acc_sum   = first ? r : psum[tail_i] + r;
    tag_cnt   = CW'($countones(tv));
    credit_ok = !last | (CW'(free) > tag_cnt);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.cfg_valid) nxt = (cfg_len == '0 || bus.cfg_pass_num == '0) ? FIN : WLOAD;
      WLOAD:   if (bus.wload_ack) nxt = WPULSE;
      WPULSE:  nxt = STREAM;
      STREAM:  if (issue_idx == len_q) nxt = DRAIN;
      DRAIN:   if (tv == '0) nxt = last ? FIN : WLOAD;
      FIN:     if (f_empty) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    bus.cfg_ready      = state == IDLE;
    bus.busy           = state != IDLE;
    bus.wload_req      = state == WLOAD;
    bus.new_weight_val = state == WPULSE;
    bus.din_ready      = state == STREAM && issue_idx < len_q && credit_ok;
    bus.slide_en       = bus.din_valid & bus.din_ready;
    bus.done           = state == FIN && f_empty;
    bus.acc_valid      = !f_empty;
    bus.acc_data       = f_empty ? '0 : fifo_dout;
  end
  // config latch, pass/window counters and index tag pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      pass_q    <= '0;
      pass_idx  <= '0;
      issue_idx <= '0;
      tv        <= '0;
      for (int k = 0; k < PIPE_LAT; k++) ti[k] <= '0;
    end else begin
      if (state == IDLE && bus.cfg_valid) begin
        len_q    <= cfg_len;
        pass_q   <= bus.cfg_pass_num;
        pass_idx <= '0;
      end
      if (state == DRAIN && tv == '0 && !last) pass_idx <= pass_idx + 1'b1;
      if (state == WPULSE) issue_idx <= '0;
      else if (bus.slide_en) issue_idx <= issue_idx + 1'b1;
      tv    <= {tv[PIPE_LAT-2:0], bus.slide_en};
      ti[0] <= issue_idx[IW-1:0];
      for (int k = 1; k < PIPE_LAT; k++) ti[k] <= ti[k-1];
    end
  end
  // partial sums: overwrite on the first pass, accumulate on middle passes
  always_ff @(posedge clk) begin
    if (tail_v && !last) psum[tail_i] <= acc_sum;
  end
  pe_row_out_fifo #(.W(ACC_W), .DEPTH(OFIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tail_v & last),
    .din  (acc_sum),
    .pop  (bus.acc_valid & bus.acc_ready),
    .dout (fifo_dout),
    .empty(f_empty),
    .free (free)
  );
endmodule

// File: tb/tb_pe_row_seq_ctrl.sv
// tb_pe_row_seq_ctrl: directed checks of pass sequencing, accumulation, credits and reset
module tb_pe_row_seq_ctrl;
  import ecg_acc_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  pe_row_seq_ctrl_if bus ();
  pe_row_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));
  int n_chk, n_pass, cyc, win_cnt, cur_len, din_mode;
  int wreq_rise, nwv_cnt, nwv_long, done_cnt, done_cyc, last_pop_cyc, s_cyc;
  logic wreq_d, nwv_d;
  logic signed [7:0]  vals [4][64];
  logic signed [7:0]  rq [3];
  logic signed [15:0] got [$];
  logic signed [15:0] e1 [4] = '{16'sd5, -16'sd3, 16'sd127, -16'sd128};
  logic signed [15:0] e2 [3] = '{16'sd30, 16'sd60, -16'sd90};
  logic signed [15:0] e3 [8] = '{-16'sd40, -16'sd30, -16'sd20, -16'sd10, 16'sd0, 16'sd10, 16'sd20, 16'sd30};
  logic signed [15:0] e4 [5] = '{16'sd10, 16'sd0, 16'sd200, -16'sd128, 16'sd254};
  task automatic chk(string tag, logic signed [31:0] act, logic signed [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask
  task automatic chk_got(string tag, int k, logic signed [15:0] exp);
    if (k < got.size()) chk(tag, got[k], exp);
    else chk(tag, -32'sd99999, exp);
  endtask
  task automatic start(int len, int pas, int eff);
    got.delete();
    win_cnt = 0;
    wreq_rise = 0;
    nwv_cnt = 0;
    nwv_long = 0;
    done_cnt = 0;
    cur_len = eff;
    @(negedge clk);
    bus.cfg_out_len = LEN_W'(len);
    bus.cfg_pass_num = PASS_W'(pas);
    bus.cfg_valid = 1;
    #2;
    s_cyc = cyc;
    chk("cfg_ready_at_start", bus.cfg_ready, 1);
    @(negedge clk);
    bus.cfg_valid = 0;
  endtask
  task automatic wait_done(int bound);
    for (int i = 0; i < bound && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    chk("done_pulses", done_cnt, 1);
  endtask
  // row model: returns the window's value PIPE_LAT cycles after slide_en, plus event monitors
  always @(negedge clk) begin
    if (rst) begin
      bus.din_valid = 0;
      bus.wload_ack = 0;
      bus.row_result = '0;
      rq = '{default: '0};
      win_cnt = 0;
      wreq_d = 0;
      nwv_d = 0;
    end else begin
      bus.din_valid = din_mode == 0 ? 1'b1 : din_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wload_ack = bus.wload_req & wreq_d;
      bus.row_result = rq[2];
      rq[2] = rq[1];
      rq[1] = rq[0];
      #1;
      cyc++;
      rq[0] = bus.slide_en ? vals[(win_cnt / cur_len) % 4][win_cnt % cur_len] : 8'sd0;
      if (bus.slide_en) win_cnt++;
      if (bus.wload_req && !wreq_d) wreq_rise++;
      wreq_d = bus.wload_req;
      if (bus.new_weight_val) begin
        if (nwv_d) nwv_long++;
        else nwv_cnt++;
      end
      nwv_d = bus.new_weight_val;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.acc_valid && bus.acc_ready) begin
        got.push_back(bus.acc_data);
        last_pop_cyc = cyc;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    bus.cfg_valid = 0;
    bus.cfg_out_len = '0;
    bus.cfg_pass_num = '0;
    bus.acc_ready = 1;
    din_mode = 0;
    cur_len = 1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wload_req", bus.wload_req, 0);
    chk("rst_nwv", bus.new_weight_val, 0);
    chk("rst_din_ready", bus.din_ready, 0);
    chk("rst_acc_valid", bus.acc_valid, 0);
    chk("rst_acc_data", bus.acc_data, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst = 0;
    // single pass passthrough
    for (int i = 0; i < 4; i++) vals[0][i] = 8'(e1[i]);
    start(4, 1, 4);
    wait_done(200);
    chk("t1_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk_got($sformatf("t1_out%0d", i), i, e1[i]);
    chk("t1_wload", wreq_rise, 1);
    chk("t1_nwv", nwv_cnt, 1);
    chk("t1_done_lat", done_cyc - last_pop_cyc, 1);
    // three-pass accumulation
    for (int p = 0; p < 3; p++) begin
      vals[p][0] = 8'sd10;
      vals[p][1] = 8'sd20;
      vals[p][2] = -8'sd30;
    end
    start(3, 3, 3);
    wait_done(400);
    chk("t2_count", got.size(), 3);
    for (int i = 0; i < 3; i++) chk_got($sformatf("t2_out%0d", i), i, e2[i]);
    chk("t2_wload", wreq_rise, 3);
    chk("t2_nwv", nwv_cnt, 3);
    chk("t2_nwv_long", nwv_long, 0);
    // back-pressure: credits stop issue once the FIFO is spoken for
    for (int i = 0; i < 8; i++) vals[0][i] = 8'(i * 10 - 40);
    bus.acc_ready = 0;
    start(8, 1, 8);
    repeat (20) @(negedge clk);
    #2;
    chk("t3_issued", win_cnt, 4);
    chk("t3_din_ready", bus.din_ready, 0);
    chk("t3_acc_valid", bus.acc_valid, 1);
    chk("t3_no_pop", got.size(), 0);
    @(negedge clk);
    bus.acc_ready = 1;
    wait_done(300);
    chk("t3_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk_got($sformatf("t3_out%0d", i), i, e3[i]);
    // gappy input, two passes
    vals[0][0] = 8'sd7;  vals[0][1] = -8'sd8; vals[0][2] = 8'sd100; vals[0][3] = -8'sd100; vals[0][4] = 8'sd127;
    vals[1][0] = 8'sd3;  vals[1][1] = 8'sd8;  vals[1][2] = 8'sd100; vals[1][3] = -8'sd28;  vals[1][4] = 8'sd127;
    din_mode = 1;
    start(5, 2, 5);
    wait_done(600);
    din_mode = 0;
    chk("t4_count", got.size(), 5);
    for (int i = 0; i < 5; i++) chk_got($sformatf("t4_out%0d", i), i, e4[i]);
    // reset in the middle of the second pass
    start(8, 2, 8);
    for (int i = 0; i < 300 && win_cnt < 10; i++) @(negedge clk);
    rst = 1;
    #2;
    chk("t5_busy", bus.busy, 0);
    chk("t5_cfg_ready", bus.cfg_ready, 1);
    chk("t5_acc_valid", bus.acc_valid, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    #2;
    chk("t5_no_done", done_cnt, 0);
    chk("t5_idle", bus.busy, 0);
    for (int i = 0; i < 4; i++) vals[0][i] = 8'(e1[i]);
    start(4, 1, 4);
    wait_done(200);
    chk("t5_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk_got($sformatf("t5_out%0d", i), i, e1[i]);
    // degenerate configs finish without loading weights
    start(0, 2, 1);
    wait_done(20);
    chk("t6_len0_lat_ok", (done_cyc - s_cyc) inside {[1:2]}, 1);
    chk("t6_len0_wload", wreq_rise, 0);
    chk("t6_len0_out", got.size(), 0);
    start(5, 0, 1);
    wait_done(20);
    chk("t6_pass0_lat_ok", (done_cyc - s_cyc) inside {[1:2]}, 1);
    chk("t6_pass0_wload", wreq_rise, 0);
    chk("t6_pass0_out", got.size(), 0);
    // over-long length is clamped to the psum depth
    for (int i = 0; i < 64; i++) vals[0][i] = 8'(i * 3 - 90);
    start(100, 1, 64);
    wait_done(1000);
    chk("t6_clamp_issued", win_cnt, 64);
    chk("t6_clamp_count", got.size(), 64);
    for (int i = 0; i < 64; i++) chk_got($sformatf("t6_out%0d", i), i, 16'(i * 3 - 90));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
